vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Scan sequencer that generates the h_count/v_count pair consumed by the sync/position decoder, paced by a pixel-clock-enable divided from the system clock. Starts and stops scanning only at frame boundaries. Issues a once-per-frame game-logic update request at vertical blank entry, with an ack handshake and overrun detection. Sits between the top level and the sync decoder in the EatUp video path.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=2); 100 MHz / 4 = 25 MHz pixel rate
HD, 640, horizontal display pixels
HF, 16, horizontal front porch
HB, 48, horizontal back porch
HR, 96, horizontal retrace
VD, 480, vertical display lines
VF, 10, vertical front porch
VB, 33, vertical back porch
VR, 2, vertical retrace
Derived: H_TOTAL = HD+HF+HB+HR (800), V_TOTAL = VD+VF+VB+VR (525)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; request scanning on/off
update_ack  in  1  game logic has consumed update_req
overrun_clr  in  1  one-clk pulse; clears overrun
h_count  out  10  current pixel column, 0..H_TOTAL-1
v_count  out  10  current line, 0..V_TOTAL-1
pix_tick  out  1  high in the last clk of each pixel period
line_start  out  1  pix_tick & h_count==0
frame_start  out  1  pix_tick & h_count==0 & v_count==0
running  out  1  high in RUN or STOPPING
update_req  out  1  per-frame update request, held until acked
overrun  out  1  sticky; new request arrived while previous still pending

Behaviour:
- Async reset (reset_n=0): state=IDLE, div=0, h_count=0, v_count=0, update_req=0, overrun=0. All outputs therefore 0. Applies immediately, including mid-frame.
- Divider: in RUN/STOPPING div counts 0..CLK_DIV-1 and wraps. pix_tick = running & (div==CLK_DIV-1). In IDLE, div is held at 0.
- Counters advance only on clk edges where pix_tick=1. h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments. v_count wraps from V_TOTAL-1 to 0. Each pixel value is held for exactly CLK_DIV clks.
- line_start and frame_start are combinational from registered state and coincide with pix_tick.
- FSM:
  - IDLE: counters held at (0,0). enable=1 -> RUN on the next edge. The first pixel period (0,0) starts in that cycle, and its frame_start fires CLK_DIV-1 clks later.
  - RUN: enable=0 -> STOPPING.
  - STOPPING: scanning continues unchanged. enable=1 -> RUN with no disturbance. On the pix_tick edge where counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0) -> IDLE.
- Vblank event: pix_tick & h_count==H_TOTAL-1 & v_count==VD-1.
- update_req handshake:
  - On a vblank event edge: if update_req=0 it sets to 1. If update_req=1 and update_ack=0, overrun sets to 1 and update_req stays 1 (no duplicate request).
  - update_ack=1 while update_req=1 clears update_req on the next edge.
  - Vblank event and ack in the same clk: update_req stays 1 (new request), overrun unchanged.
  - update_ack while update_req=0 is ignored.
- overrun clears only on overrun_clr or reset. If overrun_clr coincides with a new overrun event, the set wins.
- A pending update_req persists through STOPPING/IDLE until acked.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0]. Reset 0; increments on every frame_start and wraps 65535 -> 0. Game logic uses it for animation timing.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, enable=1, CLK_DIV=4 -> pix_tick period is 4 clks. h_count goes 0,1,2… with each value held 4 clks. First frame_start occurs at the 4th clk after RUN entry.
- Run until h_count=799 with pix_tick -> next edge gives h_count=0, v_count+1, line_start on the following pix_tick. At v_count=524, h_count=799 -> (0,0) with frame_start. Frame length is 1,680,000 clks.
- Drop enable at (h=100, v=200) -> counting continues and running=1 until the wrap to (0,0), then IDLE with counters held at 0. Re-asserting enable mid-STOPPING gives no counter glitch.
- Reach v=479, h=799 with pix_tick -> update_req=1 next clk. Ack 10 clks later -> update_req=0 the following clk, overrun=0.
- Never ack -> at the next frame's vblank, overrun=1 and update_req stays 1. overrun_clr pulse -> overrun=0 while update_req remains 1.
- Assert reset_n=0 mid-line (h=300, v=50) -> all outputs 0 immediately. Release -> IDLE until enable.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel-enable divider, h/v counters, frame-aligned start/stop
// and a per-frame update handshake. Optional macro VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HD      = 640,
  parameter int unsigned HF      = 16,
  parameter int unsigned HB      = 48,
  parameter int unsigned HR      = 96,
  parameter int unsigned VD      = 480,
  parameter int unsigned VF      = 10,
  parameter int unsigned VB      = 33,
  parameter int unsigned VR      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       update_ack,
  input  logic       overrun_clr,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       running,
  output logic       update_req,
  output logic       overrun
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = HD + HF + HB + HR;
  localparam int unsigned V_TOTAL = VD + VF + VB + VR;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             req_q, req_d;
  logic             ovr_q, ovr_d;

  logic running_c, tick_c, h_last_c, v_last_c, frame_wrap_c, vblank_c, ovr_set_c;

  // Scan position decode from registered state only
  assign running_c    = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign tick_c       = running_c && (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last_c     = (h_q == CNT_W'(H_TOTAL - 1));
  assign v_last_c     = (v_q == CNT_W'(V_TOTAL - 1));
  assign frame_wrap_c = tick_c && h_last_c && v_last_c;
  assign vblank_c     = tick_c && h_last_c && (v_q == CNT_W'(VD - 1));
  assign ovr_set_c    = vblank_c && req_q && !update_ack;

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign pix_tick    = tick_c;
  assign line_start  = tick_c && (h_q == '0);
  assign frame_start = tick_c && (h_q == '0) && (v_q == '0);
  assign running     = running_c;
  assign update_req  = req_q;
  assign overrun     = ovr_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: stopping only takes effect on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (frame_wrap_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Divider and scan counters
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (!running_c) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else if (tick_c) begin
      div_d = '0;
      if (h_last_c) begin
        h_d = '0;
        v_d = v_last_c ? '0 : (v_q + CNT_W'(1));
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Update request: a new vblank re-arms the request even if acked in the same clk
  always_comb begin
    req_d = req_q;
    ovr_d = ovr_q;
    if (vblank_c) begin
      req_d = 1'b1;
    end else if (update_ack) begin
      req_d = 1'b0;
    end
    if (ovr_set_c) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      req_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      req_q <= req_d;
      ovr_q <= ovr_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Free-running frame counter for animation timing, wraps naturally
  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_start) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl with a reduced raster and a pixel-index reference model.
module tb_vga_timing_ctrl;

  localparam int CLK_DIV = 3;
  localparam int HD = 8, HF = 2, HB = 1, HR = 3;
  localparam int VD = 5, VF = 1, VB = 2, VR = 2;
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int NPIX = HT * VT;
  localparam int FRAME_CLKS = NPIX * CLK_DIV;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        tick;
    logic        ls;
    logic        fs;
    logic        run;
    logic        req;
    logic        ov;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, enable, update_ack, overrun_clr;
  logic [9:0] h_count, v_count;
  logic pix_tick, line_start, frame_start, running, update_req, overrun;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .CLK_DIV(CLK_DIV), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .update_ack(update_ack),
    .overrun_clr(overrun_clr), .h_count(h_count), .v_count(v_count),
    .pix_tick(pix_tick), .line_start(line_start), .frame_start(frame_start),
    .running(running), .update_req(update_req), .overrun(overrun)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // Reference model: linear pixel index within a frame plus phase inside the pixel
  bit m_active, m_stop, m_req, m_ov;
  int m_phase, m_pos;
  logic [15:0] m_fc;

  task automatic model_reset();
    m_active = 0; m_stop = 0; m_req = 0; m_ov = 0;
    m_phase = 0; m_pos = 0; m_fc = '0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit tick;
    tick   = m_active && (m_phase == CLK_DIV - 1);
    e.h    = 10'(m_pos % HT);
    e.v    = 10'(m_pos / HT);
    e.tick = tick;
    e.ls   = tick && (m_pos % HT == 0);
    e.fs   = tick && (m_pos == 0);
    e.run  = m_active;
    e.req  = m_req;
    e.ov   = m_ov;
    e.fc   = m_fc;
    return e;
  endfunction

  task automatic model_edge(input bit en, input bit ack, input bit clr);
    bit tick, vb, wrap, ov_set;
    tick   = m_active && (m_phase == CLK_DIV - 1);
    vb     = tick && (m_pos == VD * HT - 1);
    wrap   = tick && (m_pos == NPIX - 1);
    ov_set = vb && m_req && !ack;
    if (vb && !m_req) m_req = 1;
    else if (!vb && m_req && ack) m_req = 0;
    if (ov_set) m_ov = 1;
    else if (clr) m_ov = 0;
    if (tick && m_pos == 0) m_fc = m_fc + 16'd1;
    if (!m_active) begin
      if (en) begin
        m_active = 1;
        m_stop = 0;
      end
    end else begin
      if (tick) m_pos = (m_pos + 1) % NPIX;
      m_phase = (m_phase + 1) % CLK_DIV;
      if (wrap && m_stop && !en) m_active = 0;
      m_stop = !en;
    end
  endtask

  // One clock of stimulus; rn=0 asserts reset asynchronously mid-cycle
  task automatic step(input logic rn, input logic en, input logic ack, input logic clr);
    @(posedge clk);
    #1;
    if (reset_n) model_edge(enable, update_ack, overrun_clr);
    reset_n = rn;
    if (!rn) model_reset();
    enable = en;
    update_ack = ack;
    overrun_clr = clr;
    sb_q.push_back(model_out());
  endtask

  function automatic logic chance(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  task automatic run_to_pos(input int pos, input int budget);
    int n = 0;
    while (!(m_active && m_pos == pos && m_phase == 0) && n < budget) begin
      step(1, 1, chance(30), 0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL run_to_pos timeout pos=%0d got_pos=%0d", pos, m_pos);
    end
  endtask

  // Monitor: pop expected values and compare every cycle; also measure frame timing
  int cyc = 0, last_fs = 0, run_start = 0;
  bit fs_valid = 0, first_pending = 0, prev_run = 0;

  always @(negedge clk) begin
    exp_t e, got;
    cyc++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      got.h = h_count; got.v = v_count; got.tick = pix_tick; got.ls = line_start;
      got.fs = frame_start; got.run = running; got.req = update_req; got.ov = overrun;
`ifdef VGA_TIMING_FRAME_CNT_EN
      got.fc = frame_cnt;
`else
      got.fc = '0;
      e.fc = '0;
`endif
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got h=%0d v=%0d tick=%b ls=%b fs=%b run=%b req=%b ov=%b fc=%0d exp h=%0d v=%0d tick=%b ls=%b fs=%b run=%b req=%b ov=%b fc=%0d",
                 cyc, got.h, got.v, got.tick, got.ls, got.fs, got.run, got.req, got.ov, got.fc,
                 e.h, e.v, e.tick, e.ls, e.fs, e.run, e.req, e.ov, e.fc);
      end
      if (!e.run) fs_valid = 0;
      if (e.run && !prev_run) begin
        run_start = cyc;
        first_pending = 1;
      end
      prev_run = e.run;
      if (frame_start === 1'b1) begin
        if (first_pending) begin
          checks++;
          if (cyc - run_start != CLK_DIV - 1) begin
            errors++;
            $display("FAIL first_frame_start latency got=%0d exp=%0d", cyc - run_start, CLK_DIV - 1);
          end
          first_pending = 0;
        end
        if (fs_valid) begin
          checks++;
          if (cyc - last_fs != FRAME_CLKS) begin
            errors++;
            $display("FAIL frame_length got=%0d exp=%0d", cyc - last_fs, FRAME_CLKS);
          end
        end
        fs_valid = 1;
        last_fs = cyc;
      end
    end
  end

  initial begin
    logic en_r;
    int n;
    reset_n = 1'b0; enable = 1'b0; update_ack = 1'b0; overrun_clr = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);

    // Free run without ack: second vblank raises overrun
    repeat (2 * FRAME_CLKS + 50) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    repeat (30) step(1, 1, 0, 0);
    step(1, 1, 1, 0);

    // Random traffic with occasional enable drops
    en_r = 1'b1;
    repeat (3 * FRAME_CLKS) begin
      if (chance(150)) en_r = ~en_r;
      step(1, en_r, chance(40), chance(100));
    end

    // Frame-aligned stop with a re-assert while stopping
    run_to_pos(3 * HT + 5, 3 * FRAME_CLKS);
    repeat (40) step(1, 0, chance(30), 0);
    repeat (5) step(1, 1, 0, 0);
    n = 0;
    while (m_active && n < 2 * FRAME_CLKS) begin
      step(1, 0, chance(30), 0);
      n++;
    end
    if (m_active) begin
      checks++;
      errors++;
      $display("FAIL stop_timeout model still active");
    end
    repeat (10) step(1, 0, 0, 0);

    // Asynchronous reset mid-line, then idle until enable
    run_to_pos(3 * HT + 7, 2 * FRAME_CLKS);
    step(0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    repeat (FRAME_CLKS + 20) step(1, 1, chance(20), 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
